hex_seq_ctrl: RTL and testbench
===============================

HEX_SEQ_CTRL -- requirements
Module: hex_seq_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, sets CLOCK_50 cycles per scan step at speed 0.
REQ-002 Parameter DEB_CYCLES, default 250000, sets key stable-low cycles, used only with DEBOUNCE_EN.
REQ-003 Port CLOCK_50, input, 1, sole clock; all state changes on its rising edge.
REQ-004 Port RESET_N, input, 1, reset, asynchronous, active-low.
REQ-005 Port KEY0, input, 1, active-low run/pause key.
REQ-006 Port KEY1, input, 1, active-low stop key.
REQ-007 Port KEY2, input, 1, active-low manual-step key.
REQ-008 Port KEY3, input, 1, active-low direction-toggle key.
REQ-009 Port SW, input, 10, SW[1:0] speed select; SW[9] show-all override; SW[8:2] unused.
REQ-010 Ports HEX0..HEX3, output, 7 each, registered active-low segment patterns {g,f,e,d,c,b,a}.
REQ-011 Port STATE, output, 2, current FSM state: 00 IDLE, 01 RUN, 10 PAUSE.
REQ-012 Port PTR, output, 2, index of the active digit.

Function
REQ-013 KEY0..KEY3 shall each pass a 2-flop synchronizer; a press is a single-cycle pulse on the synchronized high-to-low transition.
REQ-014 FSM: IDLE -KEY0-> RUN; RUN -KEY0-> PAUSE; PAUSE -KEY0-> RUN; any state -KEY1-> IDLE.
REQ-015 Priority for same-cycle presses: KEY1 over KEY0 over KEY2 over KEY3; lower-priority presses in that cycle are dropped.
REQ-016 Prescaler counts 0 to (TICK_DIV >> SW[1:0]) - 1 while in RUN and emits one tick on wrap; it holds in PAUSE and clears in IDLE and on entry to RUN.
REQ-017 On tick in RUN, PTR steps modulo 4: +1 when DIR=0, -1 when DIR=1 (3->0 and 0->3 wrap).
REQ-018 KEY2 press in PAUSE steps PTR once per the DIR rule; KEY2 is ignored in IDLE and RUN.
REQ-019 KEY3 press toggles DIR in RUN or PAUSE; it is ignored in IDLE.
REQ-020 Entering IDLE forces PTR=0, DIR=0, prescaler=0.
REQ-021 Glyphs: HEX0 'A' 0001000, HEX1 'P' 0001100, HEX2 'E' 0000110, HEX3 '1' 1111001; dash 0111111; blank 1111111.
REQ-022 In IDLE all digits show dash; in RUN/PAUSE digit PTR shows its glyph and the others show blank.
REQ-023 When SW[9]=1, all four digits show their glyphs in every state; FSM, PTR and DIR are unaffected.
REQ-024 HEX outputs update one cycle after the PTR/STATE change (registered decode).
REQ-025 A SW[1:0] change mid-count applies at once; if the count is at or above the new limit, the prescaler wraps and ticks on the next cycle.

Reset
REQ-026 RESET_N low asynchronously forces STATE=IDLE, PTR=0, DIR=0, prescaler=0, synchronizers=1, debounce counters=0 and HEX0..HEX3=1111111.
REQ-027 First post-reset HEX update (dashes) occurs on the first clock after RESET_N deasserts.
REQ-028 Reset mid-RUN discards the scan position; no press is detected from a key held low through reset release until it goes high again.

Configuration
REQ-029 Macro HEX_SEQ_DEBOUNCE_EN defined: a press is recognized only after the synchronized key has been low for DEB_CYCLES consecutive cycles, once per low period.
REQ-030 Macro HEX_SEQ_DEBOUNCE_EN undefined: press detection is per REQ-013 with no debounce counters.

Verification
REQ-031 TICK_DIV=8, SW=0: reset, press KEY0 -> STATE=01; PTR steps 0,1,2,3,0 every 8 cycles; HEX1=0001100 when PTR=1.
REQ-032 RUN, press KEY0 -> STATE=10, PTR frozen for 100 cycles; KEY2 press -> PTR+1; KEY3 then KEY2 -> PTR back.
REQ-033 KEY0 and KEY1 in the same cycle from RUN -> STATE=00, PTR=0, all HEX=0111111.
REQ-034 TICK_DIV=8, SW[1:0]=3 -> tick every cycle; SW[9]=1 -> HEX3..HEX0=1111001,0000110,0001100,0001000 with PTR unaffected.
REQ-035 RESET_N pulse low mid-RUN, between clock edges -> outputs blank immediately; STATE=00 after release.
REQ-036 With HEX_SEQ_DEBOUNCE_EN, DEB_CYCLES=4: a 3-cycle KEY0 glitch -> no change; a 4-cycle low -> exactly one RUN entry.

Source files
------------

// File: rtl/hex_seq_ctrl.sv
// hex_seq_ctrl: key-driven scanner that walks one glyph across four 7-segment digits.
// Define HEX_SEQ_DEBOUNCE_EN to require keys to stay low DEB_CYCLES cycles before a press counts.
module hex_seq_ctrl #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       KEY0,
  input  logic       KEY1,
  input  logic       KEY2,
  input  logic       KEY3,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [1:0] STATE,
  output logic [1:0] PTR
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_e;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  // Index 0..3 -> 'A', 'P', 'E', '1'
  localparam logic [3:0][6:0] GLYPHS = {7'b1111001, 7'b0000110, 7'b0001100, 7'b0001000};

  logic [3:0] keys;
  logic [3:0] sync1_q, sync2_q;
  logic [1:0] vld_q;
  logic [3:0] press;
  logic       unused_sw;

  assign keys      = {KEY3, KEY2, KEY1, KEY0};
  assign unused_sw = ^SW[8:2];

  // vld_q marks when sync2_q carries a real post-reset sample rather than its reset value
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '1;
      sync2_q <= '1;
      vld_q   <= '0;
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
    end
  end

`ifdef HEX_SEQ_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  logic [3:0][CW-1:0] deb_q;
  logic [3:0]         armed_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      deb_q   <= '0;
      armed_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!vld_q[1] || sync2_q[i]) deb_q[i] <= '0;
        else if (deb_q[i] != CW'(DEB_CYCLES)) deb_q[i] <= deb_q[i] + 1'b1;
        if (vld_q[1] && sync2_q[i]) armed_q[i] <= 1'b1;
      end
    end
  end

  // Counter saturates, so the match fires once per low period
  always_comb begin
    press = '0;
    for (int i = 0; i < 4; i++)
      press[i] = armed_q[i] & vld_q[1] & ~sync2_q[i] & (deb_q[i] == CW'(DEB_CYCLES - 1));
  end
`else
  logic [3:0] prev_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) prev_q <= '0;
    else          prev_q <= sync2_q & {4{vld_q[1]}};
  end

  assign press = prev_q & ~sync2_q;
`endif

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        dir_q, dir_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] limit;
  logic [1:0]  ptr_step;

  assign limit    = 32'(TICK_DIV) >> SW[1:0];
  assign ptr_step = dir_q ? ptr_q - 2'd1 : ptr_q + 2'd1;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only the highest-priority press acts; a mode change suppresses the scan tick that cycle
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    if (press[1]) begin
      state_d = S_IDLE;
      ptr_d   = '0;
      dir_d   = 1'b0;
      cnt_d   = '0;
    end else if (press[0]) begin
      unique case (state_q)
        S_RUN:   state_d = S_PAUSE;
        default: begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      endcase
    end else begin
      if (press[2]) begin
        if (state_q == S_PAUSE) ptr_d = ptr_step;
      end else if (press[3] && state_q != S_IDLE) begin
        dir_d = ~dir_q;
      end
      if (state_q == S_RUN) begin
        if (cnt_q + 32'd1 >= limit) begin
          cnt_d = '0;
          ptr_d = ptr_step;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    end
  end

  logic [3:0][6:0] hex_d, hex_q;

  always_comb begin
    hex_d = '1;
    for (int i = 0; i < 4; i++) begin
      if (SW[9])                 hex_d[i] = GLYPHS[i];
      else if (state_q == S_IDLE) hex_d[i] = SEG_DASH;
      else if (ptr_q == 2'(i))    hex_d[i] = GLYPHS[i];
      else                        hex_d[i] = SEG_BLANK;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) hex_q <= {4{SEG_BLANK}};
    else          hex_q <= hex_d;
  end

  assign HEX0  = hex_q[0];
  assign HEX1  = hex_q[1];
  assign HEX2  = hex_q[2];
  assign HEX3  = hex_q[3];
  assign STATE = state_q;
  assign PTR   = ptr_q;

endmodule

// File: tb/tb_hex_seq_ctrl.sv
// tb_hex_seq_ctrl: vector table, corner-case sequences and random run against a reference model.
// Build with HEX_SEQ_DEBOUNCE_EN defined to exercise the debounced key path.
module tb_hex_seq_ctrl;

  localparam int TICK_DIV = 8;
  localparam int DEB      = 4;
`ifdef HEX_SEQ_DEBOUNCE_EN
  localparam int DEB_LEN = DEB;
`else
  localparam int DEB_LEN = 1;
`endif

  localparam logic [6:0] G_A  = 7'b0001000;
  localparam logic [6:0] G_P  = 7'b0001100;
  localparam logic [6:0] G_E  = 7'b0000110;
  localparam logic [6:0] G_1  = 7'b1111001;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] BL   = 7'b1111111;
  localparam logic [27:0] H_DASH = {DASH, DASH, DASH, DASH};
  localparam logic [27:0] H_BL   = {BL, BL, BL, BL};
  localparam logic [27:0] H_A    = {BL, BL, BL, G_A};
  localparam logic [27:0] H_P    = {BL, BL, G_P, BL};
  localparam logic [27:0] H_E    = {BL, G_E, BL, BL};
  localparam logic [27:0] H_1    = {G_1, BL, BL, BL};
  localparam logic [27:0] H_ALL  = {G_1, G_E, G_P, G_A};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] keys  = 4'hF;
  logic [9:0] sw    = '0;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [1:0] state, ptr;

  hex_seq_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n),
    .KEY0(keys[0]), .KEY1(keys[1]), .KEY2(keys[2]), .KEY3(keys[3]),
    .SW(sw),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3),
    .STATE(state), .PTR(ptr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: keys become visible two edges after sampling; a press is the
  // DEB_LEN-th consecutive low sample, provided the key was seen high before.
  int          m_state, m_ptr, m_dir, m_cnt;
  logic [27:0] m_hex;
  logic [3:0]  hist_q[$];
  int          run_len[4];
  bit          seen_high[4];

  function automatic logic [27:0] view(input int st, input int p, input bit all);
    logic [6:0] gly[4];
    logic [6:0] seg;
    gly = '{G_A, G_P, G_E, G_1};
    view = '0;
    for (int d = 0; d < 4; d++) begin
      if (all)          seg = gly[d];
      else if (st == 0) seg = DASH;
      else if (d == p)  seg = gly[d];
      else              seg = BL;
      view[d*7 +: 7] = seg;
    end
  endfunction

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_dir = 0; m_cnt = 0;
    m_hex = H_BL;
    hist_q.delete();
    for (int j = 0; j < 4; j++) begin
      run_len[j] = 0;
      seen_high[j] = 0;
    end
  endtask

  task automatic model_step();
    logic [3:0] old;
    bit pr[4];
    int limit, odir;
    if (!rst_n) return;
    for (int j = 0; j < 4; j++) pr[j] = 0;
    hist_q.push_back(keys);
    if (hist_q.size() > 2) begin
      old = hist_q.pop_front();
      for (int j = 0; j < 4; j++) begin
        if (old[j]) begin
          run_len[j] = 0;
          seen_high[j] = 1;
        end else begin
          run_len[j]++;
          pr[j] = seen_high[j] && (run_len[j] == DEB_LEN);
        end
      end
    end
    m_hex = view(m_state, m_ptr, sw[9]);
    limit = TICK_DIV / (1 << sw[1:0]);
    odir  = m_dir;
    if (pr[1]) begin
      m_state = 0; m_ptr = 0; m_dir = 0; m_cnt = 0;
    end else if (pr[0]) begin
      if (m_state == 1) m_state = 2;
      else begin
        m_state = 1;
        m_cnt = 0;
      end
    end else begin
      if (pr[2]) begin
        if (m_state == 2) m_ptr = (m_ptr + (odir ? 3 : 1)) % 4;
      end else if (pr[3] && m_state != 0) begin
        m_dir = 1 - m_dir;
      end
      if (m_state == 1) begin
        m_cnt++;
        if (m_cnt >= limit) begin
          m_cnt = 0;
          m_ptr = (m_ptr + (odir ? 3 : 1)) % 4;
        end
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("model_state", state, m_state);
      chk("model_ptr", ptr, m_ptr);
      chk("model_hex", {hex3, hex2, hex1, hex0}, m_hex);
    end
  endtask

  task automatic press(input int j);
    keys[j] = 1'b0;
    tick(DEB_LEN);
    keys[j] = 1'b1;
    tick(3);
  endtask

  typedef struct {
    logic [3:0]  k;
    logic [9:0]  s;
    int          hold;
    logic [1:0]  st;
    logic [1:0]  p;
    logic [27:0] hex;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] k, input logic [9:0] s, input int hold,
                              input logic [1:0] st, input logic [1:0] p, input logic [27:0] hex);
    vec_t v;
    v.k = k; v.s = s; v.hold = hold; v.st = st; v.p = p; v.hex = hex;
    vecs.push_back(v);
  endfunction

  int hold_left[4];

  initial begin
    model_reset();
    tick(2);
    chk("reset_state", state, 2'b00);
    chk("reset_ptr", ptr, 2'b00);
    chk("reset_hex", {hex3, hex2, hex1, hex0}, H_BL);
    rst_n = 1'b1;

`ifndef HEX_SEQ_DEBOUNCE_EN
    add(4'hF, 10'h000,   3, 2'd0, 2'd0, H_DASH);
    add(4'hE, 10'h000,   1, 2'd0, 2'd0, H_DASH);
    add(4'hF, 10'h000,   2, 2'd1, 2'd0, H_DASH);
    add(4'hF, 10'h000,   1, 2'd1, 2'd0, H_A);
    add(4'hF, 10'h000,   7, 2'd1, 2'd1, H_A);
    add(4'hF, 10'h000,   1, 2'd1, 2'd1, H_P);
    add(4'hF, 10'h000,   8, 2'd1, 2'd2, H_E);
    add(4'hF, 10'h000,   8, 2'd1, 2'd3, H_1);
    add(4'hF, 10'h000,   8, 2'd1, 2'd0, H_A);
    add(4'hE, 10'h000,   1, 2'd1, 2'd0, H_A);
    add(4'hF, 10'h000,   2, 2'd2, 2'd0, H_A);
    add(4'hF, 10'h000, 100, 2'd2, 2'd0, H_A);
    add(4'hB, 10'h000,   1, 2'd2, 2'd0, H_A);
    add(4'hF, 10'h000,   3, 2'd2, 2'd1, H_P);
    add(4'h7, 10'h000,   1, 2'd2, 2'd1, H_P);
    add(4'hF, 10'h000,   3, 2'd2, 2'd1, H_P);
    add(4'hB, 10'h000,   1, 2'd2, 2'd1, H_P);
    add(4'hF, 10'h000,   3, 2'd2, 2'd0, H_A);
    add(4'hB, 10'h000,   1, 2'd2, 2'd0, H_A);
    add(4'hF, 10'h000,   3, 2'd2, 2'd3, H_1);
    add(4'hE, 10'h000,   1, 2'd2, 2'd3, H_1);
    add(4'hF, 10'h000,   2, 2'd1, 2'd3, H_1);
    add(4'hF, 10'h000,   9, 2'd1, 2'd2, H_E);
    add(4'hC, 10'h000,   1, 2'd1, 2'd2, H_E);
    add(4'hF, 10'h000,   3, 2'd0, 2'd0, H_DASH);
    add(4'hE, 10'h003,   1, 2'd0, 2'd0, H_DASH);
    add(4'hF, 10'h003,   2, 2'd1, 2'd0, H_DASH);
    add(4'hF, 10'h003,   5, 2'd1, 2'd1, H_A);
    add(4'hF, 10'h203,   1, 2'd1, 2'd2, H_ALL);
    add(4'hF, 10'h200,   3, 2'd1, 2'd2, H_ALL);
    add(4'hD, 10'h000,   1, 2'd1, 2'd2, H_E);
    add(4'hF, 10'h000,   3, 2'd0, 2'd0, H_DASH);
    add(4'hE, 10'h000,   1, 2'd0, 2'd0, H_DASH);
    add(4'hF, 10'h000,   2, 2'd1, 2'd0, H_DASH);
    add(4'hF, 10'h000,   5, 2'd1, 2'd0, H_A);
    add(4'hF, 10'h002,   1, 2'd1, 2'd1, H_A);
    add(4'hF, 10'h002,   2, 2'd1, 2'd2, H_P);
    foreach (vecs[i]) begin
      keys = vecs[i].k;
      sw   = vecs[i].s;
      tick(vecs[i].hold);
      chk($sformatf("vec%0d_state", i), state, vecs[i].st);
      chk($sformatf("vec%0d_ptr", i), ptr, vecs[i].p);
      chk($sformatf("vec%0d_hex", i), {hex3, hex2, hex1, hex0}, vecs[i].hex);
    end
    keys = 4'hF;
    sw   = '0;
`else
    tick(3);
    keys[0] = 1'b0;
    tick(3);
    keys[0] = 1'b1;
    tick(10);
    chk("deb_glitch_state", state, 2'b00);
    keys[0] = 1'b0;
    tick(4);
    keys[0] = 1'b1;
    tick(4);
    chk("deb_press_state", state, 2'b01);
    keys[0] = 1'b0;
    tick(12);
    chk("deb_long_low_state", state, 2'b10);
    keys[0] = 1'b1;
    tick(4);
    chk("deb_after_release", state, 2'b10);
`endif

    // Asynchronous reset pulse mid-RUN, entirely between clock edges
    press(1);
    press(0);
    tick(5);
    chk("prereset_state", state, 2'b01);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_hex", {hex3, hex2, hex1, hex0}, H_BL);
    chk("async_rst_state", state, 2'b00);
    chk("async_rst_ptr", ptr, 2'b00);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_hex", {hex3, hex2, hex1, hex0}, H_DASH);
    chk("post_rst_state", state, 2'b00);

    // Key held low through reset release must not count as a press
    keys[0] = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
    tick(10);
    chk("held_key_state", state, 2'b00);
    keys[0] = 1'b1;
    tick(5);
    chk("held_key_release", state, 2'b00);
    press(0);
    chk("held_key_repress", state, 2'b01);

    for (int j = 0; j < 4; j++) hold_left[j] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int j = 0; j < 4; j++) begin
        if (hold_left[j] == 0) begin
          if (j == 1) keys[j] = ($urandom_range(0, 15) != 0);
          else        keys[j] = ($urandom_range(0, 3) != 0);
          hold_left[j] = $urandom_range(1, 6);
        end else begin
          hold_left[j]--;
        end
      end
      if ($urandom_range(0, 49) == 0) sw = 10'($urandom_range(0, 1023));
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
